// File: rtl/j1_io_pkg.sv
// Shared address map and status-bit layout for the J1 I/O responder.
// The TICKS counter at IO_TICKS only exists when J1_IO_TICKS_EN is defined.
package j1_io_pkg;

  localparam logic [15:0] IO_LEDS      = 16'h0004;
  localparam logic [15:0] IO_TICKS     = 16'h0008;
  localparam logic [15:0] IO_UART_DATA = 16'h1000;
  localparam logic [15:0] IO_UART_STAT = 16'h2000;

  localparam int STAT_TX_SPACE = 0;
  localparam int STAT_RX_AVAIL = 1;
  localparam int STAT_TX_OVF   = 2;
  localparam int STAT_TX_BUSY  = 3;

  // Packed so that the field order matches the STAT_* bit indices.
  typedef struct packed {
    logic tx_busy;
    logic tx_ovf;
    logic rx_avail;
    logic tx_space;
  } stat_t;

endpackage

// File: rtl/j1_io_fifo.sv
// First-word-fall-through FIFO with wrapping pointers and a separate occupancy count.
// Push while full and pop while empty are ignored here, so callers need not gate them.
module j1_io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds no reset value; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/j1_io_port.sv
// Memory-mapped I/O responder for the J1 core: LED register, UART TX/RX FIFOs, status.
// Define J1_IO_TICKS_EN to add the free-running TICKS counter at address 0x0008.
module j1_io_port
  import j1_io_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [15:0]      mem_addr,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] io_din,
  output logic [7:0]       leds,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready
);

  logic       sel_leds, sel_data, sel_stat, sel_ticks;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic [7:0] leds_q, leds_d;
  logic       tx_ovf_q, tx_ovf_d;
  stat_t      stat;

  assign sel_leds  = (mem_addr == IO_LEDS);
  assign sel_data  = (mem_addr == IO_UART_DATA);
  assign sel_stat  = (mem_addr == IO_UART_STAT);
  assign sel_ticks = (mem_addr == IO_TICKS);

  assign tx_push  = io_wr && sel_data;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = io_rd && sel_data;
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  assign leds     = leds_q;

  j1_io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (dout[7:0]),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  j1_io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    stat.tx_space = !tx_full;
    stat.rx_avail = !rx_empty;
    stat.tx_ovf   = tx_ovf_q;
    stat.tx_busy  = !tx_empty;
  end

  // A write that finds TX full is dropped and latched as an overflow; the clear wins over nothing else on this address.
  always_comb begin
    leds_d   = leds_q;
    tx_ovf_d = tx_ovf_q;
    if (io_wr && sel_leds) leds_d = dout[7:0];
    if (io_wr && sel_stat && dout[STAT_TX_OVF]) tx_ovf_d = 1'b0;
    else if (tx_push && tx_full)                tx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q   <= '0;
      tx_ovf_q <= 1'b0;
    end else begin
      leds_q   <= leds_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

`ifdef J1_IO_TICKS_EN
  localparam int TW = (WIDTH < 32) ? WIDTH : 32;

  logic [31:0] ticks_q, ticks_d, ticks_wr;

  // A load stores dout+1 so the cycle after the write already reads dout+1.
  always_comb begin
    ticks_wr           = '0;
    ticks_wr[TW-1:0]   = dout[TW-1:0];
    ticks_d            = ticks_q + 32'd1;
    if (io_wr && sel_ticks) ticks_d = ticks_wr + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ticks_q <= '0;
    else       ticks_q <= ticks_d;
  end
`else
  logic unused_ticks;
  assign unused_ticks = sel_ticks ^ (^dout[WIDTH-1:8]);
`endif

  always_comb begin
    io_din = '0;
    if (io_rd) begin
      if (sel_leds)                    io_din[7:0] = leds_q;
      else if (sel_data && !rx_empty)  io_din[7:0] = rx_head;
      else if (sel_stat)               io_din[3:0] = stat;
`ifdef J1_IO_TICKS_EN
      else if (sel_ticks)              io_din[TW-1:0] = ticks_q[TW-1:0];
`endif
    end
  end

endmodule

// File: tb/tb_j1_io_port.sv
// Directed bench for j1_io_port: register access, TX/RX FIFO flow, status and reset.
// Read data and TX bytes are compared against an expected queue filled when stimulus is driven.
module tb_j1_io_port;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         io_rd, io_wr;
  logic [15:0]  mem_addr;
  logic [W-1:0] dout;
  logic [W-1:0] io_din;
  logic [7:0]   leds, tx_data, rx_data;
  logic         tx_valid, tx_ready, rx_valid, rx_ready;

  logic [W-1:0] exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;

  j1_io_port #(.WIDTH(W), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .mem_addr (mem_addr),
    .dout     (dout),
    .io_din   (io_din),
    .leds     (leds),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; the next rising edge acts on them.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pops the oldest expected value and compares it to the observed one.
  task automatic sb_check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed %h with no expected entry", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // Driver tasks
  task automatic io_write(input logic [15:0] a, input logic [W-1:0] d);
    io_wr = 1'b1; mem_addr = a; dout = d;
    tick();
    io_wr = 1'b0; dout = '0;
  endtask

  task automatic io_read(input string tag, input logic [15:0] a, input logic [W-1:0] exp);
    io_rd = 1'b1; mem_addr = a;
    exp_q.push_back(exp);
    #1 sb_check(tag, io_din);
    tick();
    io_rd = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; mem_addr = '0; dout = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    tick(); tick();
    #1;
    check("rst_leds", {24'd0, leds}, 32'h0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'h1);
    check("rst_io_din", io_din, 32'h0);
    reset = 1'b0;
    tick();

    // LED register and asynchronous reset
    io_write(16'h0004, 32'h5A);
    #1 check("leds_after_wr", {24'd0, leds}, 32'h5A);
    io_read("leds_rd", 16'h0004, 32'h0000005A);
    #1 reset = 1'b1;
    #1 check("leds_async_rst", {24'd0, leds}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    io_read("stat_after_rst", 16'h2000, 32'h1);

    // TX fill past full, then drain
    for (int i = 0; i < 9; i++) io_write(16'h1000, 32'h41 + i);
    io_read("stat_tx_full_ovf", 16'h2000, 32'h0C);
    #1 check("tx_head_held", {24'd0, tx_data}, 32'h41);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h41 + i);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 check("tx_valid_drain", {31'd0, tx_valid}, 32'h1);
      sb_check("tx_data_seq", {24'd0, tx_data});
      tick();
    end
    #1 check("tx_valid_empty", {31'd0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    io_read("stat_ovf_still", 16'h2000, 32'h05);
    io_write(16'h2000, 32'h4);
    io_read("stat_ovf_clr", 16'h2000, 32'h01);

    // RX basic path and read-while-empty
    rx_send(8'h10); rx_send(8'h20); rx_send(8'h30);
    io_read("stat_rx_avail", 16'h2000, 32'h03);
    io_read("rx_rd0", 16'h1000, 32'h10);
    io_read("rx_rd1", 16'h1000, 32'h20);
    io_read("rx_rd2", 16'h1000, 32'h30);
    io_read("rx_rd_empty", 16'h1000, 32'h0);
    io_read("stat_rx_empty", 16'h2000, 32'h01);

    // RX full, back-pressure, simultaneous pop and push
    for (int i = 0; i < 8; i++) rx_send(8'(i + 1));
    #1 check("rx_ready_full", {31'd0, rx_ready}, 32'h0);
    rx_valid = 1'b1; rx_data = 8'h99;
    io_read("rx_pop_while_full", 16'h1000, 32'h01);
    #1 check("rx_ready_after_pop", {31'd0, rx_ready}, 32'h1);
    tick();
    rx_valid = 1'b0;
    #1 check("rx_ready_refull", {31'd0, rx_ready}, 32'h0);
    for (int i = 2; i <= 8; i++) io_read("rx_drain", 16'h1000, W'(i));
    io_read("rx_last_99", 16'h1000, 32'h99);
    io_read("rx_empty_again", 16'h1000, 32'h0);

`ifdef J1_IO_TICKS_EN
    io_write(16'h0008, 32'hFFFFFFFE);
    io_read("ticks_ffff", 16'h0008, 32'hFFFFFFFF);
    io_read("ticks_wrap", 16'h0008, 32'h00000000);
    io_read("ticks_run", 16'h0008, 32'h00000001);
`else
    io_read("ticks_unmapped", 16'h0008, 32'h0);
`endif

    // Unmapped access and io_rd low
    rx_send(8'h77);
    io_read("unmapped_rd", 16'h0100, 32'h0);
    io_write(16'h0100, 32'hFFFFFFFF);
    mem_addr = 16'h1000; io_rd = 1'b0;
    #1 check("rd_low_din", io_din, 32'h0);
    tick();
    io_read("stat_no_pop", 16'h2000, 32'h03);
    io_read("leds_unchanged", 16'h0004, 32'h0);
    io_read("rx_after_unmapped", 16'h1000, 32'h77);

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/j1_io_port.md
Name: j1_io_port

Overview:
- Memory-mapped I/O responder that sits on the J1 core's I/O strobe bus (io_rd, io_wr, mem_addr, dout, io_din).
- Decodes the 16-bit I/O address and provides an 8-bit LED register and a byte-stream UART interface backed by TX and RX FIFOs, plus a status register.
- Read data is combinational, so the core captures it in the same cycle as the strobe.
- Read/write side effects (FIFO pop/push, register update) take effect at the next rising clock edge.

Parameters:
- WIDTH, 32, data width of the core bus; matches the core's stack width.
- FIFO_DEPTH, 8, entries per FIFO; power of two, minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- io_rd  input  1  read strobe; one cycle per access
- io_wr  input  1  write strobe; one cycle per access
- mem_addr  input  16  I/O address
- dout  input  WIDTH  write data from the core
- io_din  output  WIDTH  read data to the core, combinational
- leds  output  8  LED register
- tx_data  output  8  TX FIFO head byte
- tx_valid  output  1  TX FIFO non-empty
- tx_ready  input  1  PHY accepts tx_data this cycle
- rx_data  input  8  byte from PHY
- rx_valid  input  1  PHY presents rx_data
- rx_ready  output  1  RX FIFO not full

Behaviour:
- Address map (exact match on all 16 bits):
  - 0x0004 LEDS: R/W, bits [7:0].
  - 0x1000 UART_DATA: write pushes dout[7:0] to TX; read returns RX head zero-extended and pops.
  - 0x2000 UART_STAT:
    - bit0 tx_space (TX not full)
    - bit1 rx_avail (RX not empty)
    - bit2 tx_ovf (sticky)
    - bit3 tx_busy (TX not empty)
    - write with dout[2]=1 clears tx_ovf
  - 0x0008 TICKS: see Optional Feature.
  - Unmapped reads return 0; unmapped writes are ignored.
- io_din is 0 whenever io_rd=0; upper bits beyond the field are always 0.
- Reset, asynchronous, immediate, including mid-transfer:
  - leds=0, tx_ovf=0, both FIFOs empty, so tx_valid=0 and rx_ready=1.
  - FIFO pointers and counts are cleared.
  - Stored data contents are don't-care.
- TX path:
  - Push when io_wr & addr==0x1000 & !tx_full.
  - Write while full: data dropped, tx_ovf set at the edge. "Full" is sampled before the edge, so a same-cycle pop does not rescue the write.
  - Pop when tx_valid & tx_ready.
  - Push and pop in the same cycle on a non-full, non-empty FIFO: count unchanged, order preserved.
- RX path:
  - Push when rx_valid & rx_ready; the PHY is back-pressured, so there is no RX overflow.
  - Pop when io_rd & addr==0x1000 & !rx_empty.
  - Read while empty returns 0 and has no side effect.
  - Simultaneous push and pop are both honoured.
- FIFO semantics: first-word-fall-through; the head is visible the cycle after it is written into an empty FIFO.
- Pointer arithmetic: log2(FIFO_DEPTH)-bit pointers with natural wrap; a separate count of log2(FIFO_DEPTH)+1 bits gives full/empty.
- io_rd and io_wr together in one cycle: both act independently (the core never issues this; the block must not hang).
- Throughput: one TX byte per cycle, one RX byte per cycle.

Optional Feature:
- Macro J1_IO_TICKS_EN.
- Defined:
  - 32-bit free-running cycle counter, reset to 0, increments every clk and wraps at 2^32.
  - Reading 0x0008 returns the counter value before the edge (zero-extended or truncated to WIDTH).
  - Writing 0x0008 loads dout into the counter; the next cycle reads dout+1.
- Undefined: 0x0008 is unmapped and reads 0; no counter flops exist.

Decomposition:
- Shared package j1_io_pkg:
  - address constants IO_LEDS, IO_UART_DATA, IO_UART_STAT, IO_TICKS
  - status bit indices STAT_TX_SPACE, STAT_RX_AVAIL, STAT_TX_OVF, STAT_TX_BUSY
- One sub-module, j1_io_fifo: parameterised WIDTH/DEPTH synchronous FWFT FIFO with push, pop, full, empty and async active-high reset. It is instantiated twice, for TX and RX.

Test Plan:
- Reset, then write 0x5A to 0x0004 -> leds=0x5A next cycle; read 0x0004 gives io_din=0x0000005A; assert reset mid-run -> leds=0 immediately.
- tx_ready=0, write 0x41..0x48 (8 bytes) then a 9th byte 0x49:
  - STAT = 0x0C (tx_space=0, tx_ovf=1, tx_busy=1).
  - Raise tx_ready -> tx_data sequence 0x41..0x48 over 8 consecutive cycles, then tx_valid=0.
  - Write STAT with dout=0x4 -> STAT = 0x01.
- Drive rx bytes 0x10,0x20,0x30 -> STAT bit1=1; three reads of 0x1000 return 0x10, 0x20, 0x30; a fourth read returns 0 with the FIFO still empty.
- Fill RX to 8 bytes -> rx_ready=0; in one cycle, read 0x1000 while rx_valid=1 with 0x99 -> rx_ready=1 next cycle, and 0x99 is eventually read last.
- With J1_IO_TICKS_EN: write 0xFFFFFFFE to 0x0008 -> subsequent reads show 0xFFFFFFFF then wrap to 0x00000000. Without the macro -> read 0x0008 returns 0.
- Read unmapped 0x0100 -> io_din=0, no FIFO pointer change; io_rd=0 at 0x1000 -> io_din=0.
